// File: rtl/apple1_term_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apple1_term_pkg
// Description : Shared types and default constants for the Apple-1 video
//               terminal host write path.
// Revision    : 1.0 - initial release
// ============================================================================
package apple1_term_pkg;

   // Default character code width (ASCII; bit 7 is dropped upstream)
   localparam int DEF_DATA_W = 7;

   // Carriage return: written as a line advance rather than a glyph
   localparam logic [DEF_DATA_W-1:0] DEF_CR_CODE = 7'h0D;

   // Lowest printable code; anything below it other than CR is discarded
   localparam logic [DEF_DATA_W-1:0] DEF_SP_CODE = 7'h20;

   // Host write handshake states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      WRITE   = 2'd2,
      RELEASE = 2'd3
   } wr_state_t;

endpackage : apple1_term_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : 1-bit rising-edge detector. The previous input level is held
//               in a register; the rise output is high for the cycle in which
//               the input is 1 and was 0 on the previous clock.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic r_d_q;

   // Track the previous level of the input; cleared so a level already high
   // when reset releases is seen as a fresh rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_d_q <= 1'b0;
      end else begin
         r_d_q <= d;
      end
   end

   assign rise = d & ~r_d_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/char_write_sync.sv
`default_nettype none
// ============================================================================
// Module      : char_write_sync
// Description : Host-to-terminal character write handshake. Captures a code
//               on the rising edge of DA, waits for the scan timing's cursor
//               write window, issues a single write strobe and keeps RDA low
//               until the host drops DA.
// Revision    : 1.0 - initial release
// ============================================================================
module char_write_sync
   import apple1_term_pkg::*;
#(
   parameter int                DATA_W  = DEF_DATA_W,
   parameter logic [DATA_W-1:0] CR_CODE = DATA_W'(DEF_CR_CODE),
   parameter logic [DATA_W-1:0] SP_CODE = DATA_W'(DEF_SP_CODE)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              da,
   input  logic [DATA_W-1:0] din,
   input  logic              wr_window,
   output logic              rda,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_is_cr
);

   wr_state_t r_state;
   wr_state_t w_state_nxt;
   logic      w_da_rise;
   logic      w_rda_nxt;
   logic      w_wr_en_nxt;
   logic      w_load;
   logic      w_is_cr_nxt;

   rise_detect u_da_rise (
      .clk   (clk),
      .reset (reset),
      .d     (da),
      .rise  (w_da_rise)
   );

   // Next-state and next-output decode. Every output is computed here one
   // cycle ahead and registered below, so no input reaches an output
   // combinationally. A window arriving on the capture edge is seen while
   // still in IDLE and therefore ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_rda_nxt   = 1'b0;
      w_wr_en_nxt = 1'b0;
      w_load      = 1'b0;
      w_is_cr_nxt = wr_is_cr;
      case (r_state)
         IDLE: begin
            w_rda_nxt = 1'b1;
            if (w_da_rise) begin
               w_rda_nxt = 1'b0;
               if (din == CR_CODE) begin
                  w_load      = 1'b1;
                  w_is_cr_nxt = 1'b1;
                  w_state_nxt = ARMED;
               end else if (din >= SP_CODE) begin
                  w_load      = 1'b1;
                  w_is_cr_nxt = 1'b0;
                  w_state_nxt = ARMED;
               end else begin
                  // Non-printable control code: acknowledge but never write
                  w_state_nxt = RELEASE;
               end
            end
         end
         ARMED: begin
            if (wr_window) begin
               w_wr_en_nxt = 1'b1;
               w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            w_state_nxt = RELEASE;
         end
         RELEASE: begin
            // Hold busy until DA drops so a held strobe yields one write only
            if (!da) begin
               w_rda_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_rda_nxt   = 1'b1;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, handshake outputs and the character latch. The latch loads only
   // on an accepted capture so later din activity cannot disturb wr_data.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         rda      <= 1'b1;
         wr_en    <= 1'b0;
         wr_data  <= '0;
         wr_is_cr <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         rda      <= w_rda_nxt;
         wr_en    <= w_wr_en_nxt;
         wr_is_cr <= w_is_cr_nxt;
         if (w_load) begin
            wr_data <= din;
         end
      end
   end

endmodule : char_write_sync
`default_nettype wire

// File: tb/tb_char_write_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_char_write_sync
// Description : Self-checking bench for char_write_sync. Table of host
//               transactions plus hand-written reset, race and mid-wait
//               reset sequences; write strobes are checked against a queue
//               of expected characters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_write_sync;
   import apple1_term_pkg::*;

   localparam int DW = DEF_DATA_W;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic          da        = 1'b0;
   logic          wr_window = 1'b0;
   logic [DW-1:0] din       = '0;
   logic          rda;
   logic          wr_en;
   logic          wr_is_cr;
   logic [DW-1:0] wr_data;

   char_write_sync #(.DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .da        (da),
      .din       (din),
      .wr_window (wr_window),
      .rda       (rda),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_is_cr  (wr_is_cr)
   );

   // Free-running clock, 10 ns period
   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          cr;
   } exp_t;

   typedef struct {
      logic [DW-1:0] din;
      logic [DW-1:0] chg;
      logic          exp_wr;
      logic          exp_cr;
      int            windows;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vt[10];
   int   checks   = 0;
   int   errors   = 0;
   int   wr_count = 0;
   logic prev_wr  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) step();
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expected
   // character and must never follow a strobe on the previous cycle.
   always @(posedge clk) begin
      #2;
      if (wr_en === 1'b1) begin
         wr_count++;
         check("wr_en_consecutive", 32'(prev_wr), 32'd0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr_en: got wr_en=1 data 0x%0h expected no write at %0t", wr_data, $time);
         end else begin
            mon_e = sb.pop_front();
            check("sb_wr_data", 32'(wr_data), 32'(mon_e.data));
            check("sb_wr_is_cr", 32'(wr_is_cr), 32'(mon_e.cr));
         end
      end
      prev_wr = wr_en;
   end

   // Watchdog so the bench always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w0;
      exp_t e;

      //        din     chg     wr  cr  windows
      vt[0] = '{7'h41, 7'h42, 1'b1, 1'b0, 1};
      vt[1] = '{7'h0D, 7'h41, 1'b1, 1'b1, 1};
      vt[2] = '{7'h07, 7'h41, 1'b0, 1'b0, 3};
      vt[3] = '{7'h7E, 7'h00, 1'b1, 1'b0, 2};
      vt[4] = '{7'h20, 7'h1F, 1'b1, 1'b0, 1};
      vt[5] = '{7'h1F, 7'h20, 1'b0, 1'b0, 1};
      vt[6] = '{7'h41, 7'h42, 1'b1, 1'b0, 4};
      vt[7] = '{7'h7F, 7'h0D, 1'b1, 1'b0, 1};
      vt[8] = '{7'h00, 7'h41, 1'b0, 1'b0, 1};
      vt[9] = '{7'h0C, 7'h0D, 1'b0, 1'b0, 2};

      // Reset held for three cycles
      reset = 1'b1;
      tick(3);
      check("rst_rda", 32'(rda), 32'd1);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_wr_is_cr", 32'(wr_is_cr), 32'd0);
      reset = 1'b0;
      tick(2);

      // Printable character, window 20 cycles after capture
      din = 7'h41;
      da  = 1'b1;
      step();
      check("p_rda_busy", 32'(rda), 32'd0);
      tick(19);
      e = '{data: 7'h41, cr: 1'b0};
      sb.push_back(e);
      wr_window = 1'b1;
      step();
      wr_window = 1'b0;
      check("p_wr_en_latency", 32'(wr_en), 32'd1);
      check("p_wr_data", 32'(wr_data), 32'h41);
      step();
      check("p_wr_en_single", 32'(wr_en), 32'd0);
      check("p_rda_held", 32'(rda), 32'd0);
      da = 1'b0;
      step();
      check("p_rda_idle", 32'(rda), 32'd1);
      tick(2);

      // Table of host transactions
      for (int i = 0; i < 10; i++) begin
         w0  = wr_count;
         din = vt[i].din;
         da  = 1'b1;
         step();
         check("t_rda_busy", 32'(rda), 32'd0);
         din = vt[i].chg;
         for (int k = 0; k < vt[i].windows; k++) begin
            tick(5);
            if (k == 0 && vt[i].exp_wr) begin
               e = '{data: vt[i].din, cr: vt[i].exp_cr};
               sb.push_back(e);
            end
            wr_window = 1'b1;
            step();
            wr_window = 1'b0;
            check("t_wr_en_after_window", 32'(wr_en), (k == 0) ? 32'(vt[i].exp_wr) : 32'd0);
         end
         tick(2);
         check("t_rda_held", 32'(rda), 32'd0);
         da = 1'b0;
         step();
         check("t_rda_release", 32'(rda), 32'd1);
         check("t_write_count", 32'(wr_count - w0), 32'(vt[i].exp_wr));
         tick(2);
      end

      // Capture edge coincident with a window: that window must not count
      w0        = wr_count;
      din       = 7'h55;
      da        = 1'b1;
      wr_window = 1'b1;
      step();
      wr_window = 1'b0;
      check("race_no_wr_on_capture", 32'(wr_en), 32'd0);
      step();
      check("race_no_wr_next", 32'(wr_en), 32'd0);
      tick(3);
      check("race_count_before", 32'(wr_count - w0), 32'd0);
      e = '{data: 7'h55, cr: 1'b0};
      sb.push_back(e);
      wr_window = 1'b1;
      step();
      wr_window = 1'b0;
      check("race_wr_next_window", 32'(wr_en), 32'd1);
      step();
      da = 1'b0;
      step();
      check("race_rda_idle", 32'(rda), 32'd1);
      check("race_count", 32'(wr_count - w0), 32'd1);
      tick(2);

      // DA falling while armed: write still happens, then release exits
      w0  = wr_count;
      din = 7'h5A;
      da  = 1'b1;
      step();
      tick(2);
      da = 1'b0;
      tick(2);
      check("dafall_rda_busy", 32'(rda), 32'd0);
      e = '{data: 7'h5A, cr: 1'b0};
      sb.push_back(e);
      wr_window = 1'b1;
      step();
      wr_window = 1'b0;
      check("dafall_wr_en", 32'(wr_en), 32'd1);
      step();
      step();
      check("dafall_rda_idle", 32'(rda), 32'd1);
      check("dafall_count", 32'(wr_count - w0), 32'd1);
      tick(2);

      // Reset while armed, one cycle before the window: the write is dropped
      w0  = wr_count;
      din = 7'h41;
      da  = 1'b1;
      step();
      tick(3);
      reset = 1'b1;
      da    = 1'b0;
      step();
      reset = 1'b0;
      check("rarm_rda", 32'(rda), 32'd1);
      check("rarm_wr_data", 32'(wr_data), 32'd0);
      wr_window = 1'b1;
      step();
      wr_window = 1'b0;
      check("rarm_no_wr_en", 32'(wr_en), 32'd0);
      tick(3);
      check("rarm_count", 32'(wr_count - w0), 32'd0);
      check("rarm_rda_idle", 32'(rda), 32'd1);

      // Window while idle has no effect
      wr_window = 1'b1;
      step();
      wr_window = 1'b0;
      check("idle_window_no_wr", 32'(wr_en), 32'd0);
      tick(3);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_char_write_sync
`default_nettype wire
